// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU.
// Holds the decoded instruction for one cycle, forwards operands from EX/MEM
// and MEM/WB, selects the immediate and detects load-use hazards.
//
// Stage control: the stage loads every cycle unless held. flush_i loads a
// bubble and overrides stall_i. stall_i holds the current contents. A detected
// load-use hazard, or valid_i=0, loads a bubble. A bubble carries alu_ctrl=add
// with zero operands, so the ALU never sees an undefined op.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  input  logic [RADDR-1:0] rs1_addr_i,
  input  logic [RADDR-1:0] rs2_addr_i,
  input  logic [RADDR-1:0] rd_addr_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             alu_src_i,
  input  logic [2:0]       alu_ctrl_i,
  input  logic             reg_write_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [RADDR-1:0] exmem_rd_i,
  input  logic             exmem_we_i,
  input  logic [XLEN-1:0]  exmem_data_i,
  input  logic [RADDR-1:0] memwb_rd_i,
  input  logic             memwb_we_i,
  input  logic [XLEN-1:0]  memwb_data_i,
  output logic [XLEN-1:0]  data1_o,
  output logic [XLEN-1:0]  data2_o,
  output logic [2:0]       alu_ctrl_o,
  output logic [XLEN-1:0]  store_data_o,
  output logic [RADDR-1:0] rd_addr_o,
  output logic             reg_write_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             valid_o,
  output logic             hazard_o
);

  typedef struct packed {
    logic             valid;
    logic [RADDR-1:0] rs1;
    logic [RADDR-1:0] rs2;
    logic [RADDR-1:0] rd;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic             alu_src;
    logic [2:0]       alu_ctrl;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
  } stage_t;

  localparam stage_t BUBBLE = '{
    valid: 1'b0, rs1: '0, rs2: '0, rd: '0,
    rs1_data: '0, rs2_data: '0, imm: '0,
    alu_src: 1'b0, alu_ctrl: 3'b001,
    reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0
  };

  stage_t q;
  stage_t d;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  // Load-use: the registered load writes a register the decode slot reads.
  assign hazard_o = valid_i & q.valid & q.mem_read & (q.rd != '0) &
                    ((q.rd == rs1_addr_i) | (q.rd == rs2_addr_i));

  // Next stage contents: bubble on flush, hazard or empty decode slot.
  always_comb begin
    d = BUBBLE;
    if (!flush_i && !hazard_o && valid_i) begin
      d.valid     = 1'b1;
      d.rs1       = rs1_addr_i;
      d.rs2       = rs2_addr_i;
      d.rd        = rd_addr_i;
      d.rs1_data  = rs1_data_i;
      d.rs2_data  = rs2_data_i;
      d.imm       = imm_i;
      d.alu_src   = alu_src_i;
      d.alu_ctrl  = alu_ctrl_i;
      d.reg_write = reg_write_i;
      d.mem_read  = mem_read_i;
      d.mem_write = mem_write_i;
    end
  end

  // Stage register; stall holds unless a flush overrides it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q <= BUBBLE;
    end else if (flush_i || !stall_i) begin
      q <= d;
    end
  end

  // Operand forwarding; EX/MEM is newer so it wins, and x0 never forwards.
  always_comb begin
    fwd_a = q.rs1_data;
    if (exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == q.rs1)) begin
      fwd_a = exmem_data_i;
    end else if (memwb_we_i && (memwb_rd_i != '0) && (memwb_rd_i == q.rs1)) begin
      fwd_a = memwb_data_i;
    end
    fwd_b = q.rs2_data;
    if (exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == q.rs2)) begin
      fwd_b = exmem_data_i;
    end else if (memwb_we_i && (memwb_rd_i != '0) && (memwb_rd_i == q.rs2)) begin
      fwd_b = memwb_data_i;
    end
  end

  assign data1_o      = fwd_a;
  assign data2_o      = q.alu_src ? q.imm : fwd_b;
  assign store_data_o = fwd_b;
  assign alu_ctrl_o   = q.alu_ctrl;
  assign rd_addr_o    = q.rd;
  assign reg_write_o  = q.reg_write;
  assign mem_read_o   = q.mem_read;
  assign mem_write_o  = q.mem_write;
  assign valid_o      = q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random traffic,
// checked against a model of the instruction currently held in EX.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [31:0] rs1_data_i, rs2_data_i, imm_i;
  logic        alu_src_i;
  logic [2:0]  alu_ctrl_i;
  logic        reg_write_i, mem_read_i, mem_write_i;
  logic        stall_i, flush_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic        exmem_we_i, memwb_we_i;
  logic [31:0] exmem_data_i, memwb_data_i;
  logic [31:0] data1_o, data2_o, store_data_o;
  logic [2:0]  alu_ctrl_o;
  logic [4:0]  rd_addr_o;
  logic        reg_write_o, mem_read_o, mem_write_o, valid_o, hazard_o;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .alu_src_i(alu_src_i), .alu_ctrl_i(alu_ctrl_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .exmem_rd_i(exmem_rd_i), .exmem_we_i(exmem_we_i), .exmem_data_i(exmem_data_i),
    .memwb_rd_i(memwb_rd_i), .memwb_we_i(memwb_we_i), .memwb_data_i(memwb_data_i),
    .data1_o(data1_o), .data2_o(data2_o), .alu_ctrl_o(alu_ctrl_o),
    .store_data_o(store_data_o), .rd_addr_o(rd_addr_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .valid_o(valid_o), .hazard_o(hazard_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // Model: the instruction sitting in EX
  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] v1, v2, imm;
    logic        use_imm;
    logic [2:0]  op;
    logic        rw, mr, mw;
  } instr_t;

  instr_t m;

  function automatic instr_t nop_instr();
    instr_t b;
    b = '{valid: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, v1: 32'd0, v2: 32'd0,
          imm: 32'd0, use_imm: 1'b0, op: 3'b001, rw: 1'b0, mr: 1'b0, mw: 1'b0};
    return b;
  endfunction

  // Newest producer of a register wins; x0 is hard-wired and never bypassed.
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return rf;
    if (exmem_we_i && exmem_rd_i == r) return exmem_data_i;
    if (memwb_we_i && memwb_rd_i == r) return memwb_data_i;
    return rf;
  endfunction

  function automatic logic load_use();
    return valid_i && m.valid && m.mr && m.rd != 5'd0 &&
           (m.rd == rs1_addr_i || m.rd == rs2_addr_i);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] b;
    b = operand(m.rs2, m.v2);
    check({tag, "/data1"}, data1_o, operand(m.rs1, m.v1));
    check({tag, "/data2"}, data2_o, m.use_imm ? m.imm : b);
    check({tag, "/store"}, store_data_o, b);
    check({tag, "/op"}, {29'd0, alu_ctrl_o}, {29'd0, m.op});
    check({tag, "/rd"}, {27'd0, rd_addr_o}, {27'd0, m.rd});
    check({tag, "/ctl"}, {28'd0, valid_o, reg_write_o, mem_read_o, mem_write_o},
          {28'd0, m.valid, m.rw, m.mr, m.mw});
    check({tag, "/hazard"}, {31'd0, hazard_o}, {31'd0, load_use()});
  endtask

  // Drivers
  task automatic set_decode(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [4:0] rd, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] imm,
                            input logic src, input logic [2:0] op,
                            input logic rw, input logic mr, input logic mw);
    valid_i = v; rs1_addr_i = a1; rs2_addr_i = a2; rd_addr_i = rd;
    rs1_data_i = d1; rs2_data_i = d2; imm_i = imm; alu_src_i = src;
    alu_ctrl_i = op; reg_write_i = rw; mem_read_i = mr; mem_write_i = mw;
  endtask

  task automatic set_fwd(input logic ewe, input logic [4:0] erd, input logic [31:0] ed,
                         input logic mwe, input logic [4:0] mrd, input logic [31:0] md);
    exmem_we_i = ewe; exmem_rd_i = erd; exmem_data_i = ed;
    memwb_we_i = mwe; memwb_rd_i = mrd; memwb_data_i = md;
  endtask

  // One clock edge; the model takes the decision from pre-edge inputs.
  task automatic tick();
    instr_t nxt;
    if (flush_i) nxt = nop_instr();
    else if (stall_i) nxt = m;
    else if (load_use() || !valid_i) nxt = nop_instr();
    else nxt = '{valid: 1'b1, rs1: rs1_addr_i, rs2: rs2_addr_i, rd: rd_addr_i,
                 v1: rs1_data_i, v2: rs2_data_i, imm: imm_i, use_imm: alu_src_i,
                 op: alu_ctrl_i, rw: reg_write_i, mr: mem_read_i, mw: mem_write_i};
    @(posedge clk_i);
    m = nxt;
    #1;
  endtask

  task automatic rand_inputs();
    logic [2:0] ops [5];
    ops = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
    set_decode($urandom_range(3, 0) != 0, 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
               5'($urandom_range(7, 0)), $urandom, $urandom, $urandom,
               1'($urandom_range(1, 0)), ops[$urandom_range(4, 0)],
               1'($urandom_range(1, 0)), $urandom_range(2, 0) == 0, 1'($urandom_range(1, 0)));
    set_fwd(1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), $urandom,
            1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), $urandom);
    stall_i = $urandom_range(7, 0) == 0;
    flush_i = $urandom_range(9, 0) == 0;
  endtask

  initial begin
    m = nop_instr();
    rst_n_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    set_decode(0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset_state");

    // Release between edges; the next edge captures decode normally.
    set_decode(1, 5'd1, 5'd2, 5'd9, 32'h5, 32'h3, 32'h7, 1'b1, 3'b001, 1, 0, 0);
    rst_n_i = 1'b1;
    tick();
    check_all("plain_capture");
    check("plain_data1", data1_o, 32'h5);
    check("plain_data2", data2_o, 32'h7);
    check("plain_op", {29'd0, alu_ctrl_o}, 32'd1);

    // Forwarding priority on operand A
    set_decode(1, 5'd3, 5'd5, 5'd7, 32'h11, 32'h22, 32'h0, 1'b0, 3'b010, 1, 0, 0);
    tick();
    set_fwd(1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
    #1;
    check("fwd_exmem_wins", data1_o, 32'hAA);
    exmem_we_i = 1'b0;
    #1;
    check("fwd_memwb", data1_o, 32'hBB);
    check_all("fwd_memwb_all");
    set_decode(1, 5'd0, 5'd0, 5'd8, 32'h55, 32'h66, 32'h0, 1'b0, 3'b100, 1, 0, 0);
    set_fwd(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
    tick();
    check("fwd_x0_blocked", data1_o, 32'h55);
    check_all("fwd_x0_all");
    set_fwd(0, 0, 0, 0, 0, 0);

    // Load-use: load to x4, then a store reading x4
    set_decode(1, 5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 32'h8, 1'b1, 3'b001, 1, 1, 0);
    tick();
    set_decode(1, 5'd2, 5'd4, 5'd0, 32'h200, 32'hDEAD, 32'hC, 1'b1, 3'b001, 0, 0, 1);
    #1;
    check("lu_hazard", {31'd0, hazard_o}, 32'd1);
    tick();
    check("lu_bubble", {31'd0, valid_o}, 32'd0);
    check_all("lu_bubble_all");
    tick();
    set_fwd(0, 0, 0, 1, 5'd4, 32'h1234);
    #1;
    check("lu_store_fwd", store_data_o, 32'h1234);
    check_all("lu_capture_all");

    // Stall holds for three cycles even while decode changes
    stall_i = 1'b1;
    set_decode(1, 5'd6, 5'd7, 5'd3, 32'h1, 32'h2, 32'h3, 1'b0, 3'b101, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("stall_hold");
      check("stall_valid", {31'd0, valid_o}, 32'd1);
    end
    flush_i = 1'b1;
    tick();
    check("stall_flush_valid", {31'd0, valid_o}, 32'd0);
    check("stall_flush_op", {29'd0, alu_ctrl_o}, 32'd1);
    check_all("stall_flush_all");
    stall_i = 1'b0; flush_i = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);

    // Stall wins over a hazard: no bubble, hazard stays up
    set_decode(1, 5'd1, 5'd0, 5'd5, 32'h10, 32'h0, 32'h4, 1'b1, 3'b001, 1, 1, 0);
    tick();
    set_decode(1, 5'd5, 5'd2, 5'd6, 32'h0, 32'h0, 32'h0, 1'b0, 3'b010, 1, 0, 0);
    stall_i = 1'b1;
    tick();
    check("stall_haz_valid", {30'd0, valid_o, mem_read_o}, 32'd3);
    check("stall_haz_hazard", {31'd0, hazard_o}, 32'd1);
    stall_i = 1'b0;

    // Operand B immediate vs. forwarded store data
    set_decode(1, 5'd1, 5'd6, 5'd2, 32'h0, 32'h22, 32'h10, 1'b1, 3'b001, 1, 0, 0);
    tick();
    tick();
    set_fwd(1, 5'd6, 32'h99, 0, 0, 0);
    #1;
    check("immb_data2", data2_o, 32'h10);
    check("immb_store", store_data_o, 32'h99);

    // Asynchronous reset mid-cycle with a valid instruction loaded
    set_decode(1, 5'd3, 5'd4, 5'd11, 32'h77, 32'h88, 32'h0, 1'b0, 3'b011, 1, 0, 1);
    tick();
    #2;
    set_fwd(1, 5'd3, 32'hAA, 1, 5'd4, 32'hBB);
    rst_n_i = 1'b0;
    m = nop_instr();
    #1;
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_op", {29'd0, alu_ctrl_o}, 32'd1);
    check("rst_data1", data1_o, 32'd0);
    check("rst_rd", {27'd0, rd_addr_o}, 32'd0);
    check_all("rst_all");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      #1;
      check("rand_hazard", {31'd0, hazard_o}, {31'd0, load_use()});
      tick();
      check_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
